io_led_seg_out: RTL and testbench

Output-side peripheral fed by the IO decode stage. It registers CPU store data presented with the LED chip selects and drives the board outputs. The low chip select loads a 16-bit LED register. The high chip select loads a 32-bit display register, which is shown as eight hex digits on a time-multiplexed, common-anode 7-segment display. All board outputs are registered and glitch-free.

---
 rtl/io_led_seg_out_if.sv | 18 +
 rtl/io_led_seg_out.sv | 96 +++++++++
 tb/tb_io_led_seg_out.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_led_seg_out_if.sv
// Store-side bus from the IO decode stage into the LED / 7-segment peripheral.
interface io_led_seg_out_if;
    logic        led_low_cs;
    logic        led_high_cs;
    logic [31:0] w_data;

    modport master (
        output led_low_cs,
        output led_high_cs,
        output w_data
    );

    modport slave (
        input  led_low_cs,
        input  led_high_cs,
        input  w_data
    );
endinterface

// File: rtl/io_led_seg_out.sv
// LED register plus an eight-digit, time-multiplexed, common-anode hex display.
// All board outputs come straight from flops.
module io_led_seg_out #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter bit          BLANK_LZ = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    io_led_seg_out_if.slave    bus,
    output logic [15:0]        led,
    output logic [7:0]         seg,
    output logic [7:0]         an
);

    localparam int unsigned PC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PC_W-1:0] PC_MAX = PC_W'(SCAN_DIV - 1);

    logic [31:0]     disp;
    logic [PC_W-1:0] pc;
    logic [2:0]      idx;

    logic [3:0]      nib_c;
    logic [31:0]     upper_c;
    logic            blank_c;
    logic [7:0]      hex_c;

    // CPU store capture; both strobes may load from the same data word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led  <= 16'h0000;
            disp <= 32'h0000_0000;
        end else begin
            if (bus.led_low_cs) begin
                led <= bus.w_data[15:0];
            end
            if (bus.led_high_cs) begin
                disp <= bus.w_data;
            end
        end
    end

    // Dwell prescaler and digit index; index wraps 7 -> 0 naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc  <= '0;
            idx <= 3'd0;
        end else if (pc == PC_MAX) begin
            pc  <= '0;
            idx <= idx + 3'd1;
        end else begin
            pc  <= pc + PC_W'(1);
        end
    end

    // Select the active nibble, decide blanking and decode to active-low segments
    always_comb begin
        nib_c   = disp[{idx, 2'b00} +: 4];
        upper_c = disp >> {idx, 2'b00};
        blank_c = BLANK_LZ && (idx != 3'd0) && (upper_c == 32'h0000_0000);
        hex_c   = 8'hFF;
        case (nib_c)
            4'h0: hex_c = 8'hC0;
            4'h1: hex_c = 8'hF9;
            4'h2: hex_c = 8'hA4;
            4'h3: hex_c = 8'hB0;
            4'h4: hex_c = 8'h99;
            4'h5: hex_c = 8'h92;
            4'h6: hex_c = 8'h82;
            4'h7: hex_c = 8'hF8;
            4'h8: hex_c = 8'h80;
            4'h9: hex_c = 8'h90;
            4'hA: hex_c = 8'h88;
            4'hB: hex_c = 8'h83;
            4'hC: hex_c = 8'hC6;
            4'hD: hex_c = 8'hA1;
            4'hE: hex_c = 8'h86;
            4'hF: hex_c = 8'h8E;
            default: hex_c = 8'hFF;
        endcase
    end

    // Registered pin drive so anodes and segments always switch on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 8'hFE;
            seg <= 8'hC0;
        end else if (blank_c) begin
            an  <= 8'hFF;
            seg <= 8'hFF;
        end else begin
            an  <= ~(8'h01 << idx);
            seg <= hex_c;
        end
    end

endmodule

// File: tb/tb_io_led_seg_out.sv
// Bench for io_led_seg_out: four parameterisations share one bus and reset and
// are compared every cycle against a time-based model of the display.
module tb_io_led_seg_out;

    localparam int NDUT = 4;
    localparam int unsigned DIV [NDUT] = '{4, 4, 1000, 1};
    localparam bit          BLK [NDUT] = '{1'b0, 1'b1, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    io_led_seg_out_if bus();

    logic [15:0] led_w [NDUT];
    logic [7:0]  seg_w [NDUT];
    logic [7:0]  an_w  [NDUT];

    io_led_seg_out #(.SCAN_DIV(4),    .BLANK_LZ(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus), .led(led_w[0]), .seg(seg_w[0]), .an(an_w[0]));
    io_led_seg_out #(.SCAN_DIV(4),    .BLANK_LZ(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus), .led(led_w[1]), .seg(seg_w[1]), .an(an_w[1]));
    io_led_seg_out #(.SCAN_DIV(1000), .BLANK_LZ(1'b0)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus), .led(led_w[2]), .seg(seg_w[2]), .an(an_w[2]));
    io_led_seg_out #(.SCAN_DIV(1),    .BLANK_LZ(1'b1)) u3 (.clk(clk), .rst_n(rst_n), .bus(bus), .led(led_w[3]), .seg(seg_w[3]), .an(an_w[3]));

    // Model state: edges since reset release, LED value, display word, and the
    // display word the pins currently reflect (the one held before the last edge)
    logic [15:0] m_led;
    logic [31:0] m_disp;
    logic [31:0] m_shown;
    longint      m_edges;

    int checks = 0;
    int passed = 0;

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
            4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
            4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
            4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
        endcase
    endfunction

    // Digit on the pins: the one whose dwell covered the previous edge
    function automatic int digit_of(input int k);
        if (m_edges == 0) return 0;
        return int'(((m_edges - 1) / longint'(DIV[k])) % 8);
    endfunction

    function automatic bit blanked(input int k);
        int d;
        d = digit_of(k);
        return BLK[k] && (d > 0) && ((m_shown >> (4 * d)) == 32'h0);
    endfunction

    function automatic logic [7:0] exp_an(input int k);
        logic [7:0] one;
        one = 8'h01;
        if (blanked(k)) return 8'hFF;
        return ~(one << digit_of(k));
    endfunction

    function automatic logic [7:0] exp_seg(input int k);
        if (blanked(k)) return 8'hFF;
        return hex7(m_shown[4 * digit_of(k) +: 4]);
    endfunction

    // One rising edge with model update, then sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        m_shown = m_disp;
        if (bus.led_low_cs)  m_led  = bus.w_data[15:0];
        if (bus.led_high_cs) m_disp = bus.w_data;
        m_edges++;
        #1;
    endtask

    task automatic bus_idle();
        bus.led_low_cs  = 1'b0;
        bus.led_high_cs = 1'b0;
        bus.w_data      = 32'h0;
    endtask

    task automatic test_reset();
        // Run a little, then reset asynchronously between edges
        bus.led_low_cs = 1'b1; bus.led_high_cs = 1'b1; bus.w_data = 32'h1234_5678;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        m_led = 16'h0; m_disp = 32'h0; m_shown = 32'h0; m_edges = 0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (led_w[k] !== 16'h0000 || an_w[k] !== 8'hFE || seg_w[k] !== 8'hC0)
                $display("FAIL reset_async dut%0d: led=%h an=%h seg=%h, want led=0000 an=fe seg=c0", k, led_w[k], an_w[k], seg_w[k]);
            else passed++;
        end
        // A write sampled during reset is lost
        tick();
        m_led = 16'h0; m_disp = 32'h0; m_shown = 32'h0; m_edges = 0;
        checks++;
        if (led_w[0] !== 16'h0000 || seg_w[0] !== 8'hC0)
            $display("FAIL reset_write_lost: led=%h seg=%h, want 0000 c0", led_w[0], seg_w[0]);
        else passed++;
        bus_idle();
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks++;
            if (an_w[0] !== ((e <= 4) ? 8'hFE : 8'hFD))
                $display("FAIL release_dwell edge %0d: an=%h, want %h", e, an_w[0], (e <= 4) ? 8'hFE : 8'hFD);
            else passed++;
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (led_w[k] !== m_led || an_w[k] !== exp_an(k) || seg_w[k] !== exp_seg(k))
                    $display("FAIL release_model dut%0d edge %0d: led=%h an=%h seg=%h, want led=%h an=%h seg=%h",
                             k, m_edges, led_w[k], an_w[k], seg_w[k], m_led, exp_an(k), exp_seg(k));
                else passed++;
            end
        end
    endtask

    task automatic test_led_write();
        bus.led_low_cs = 1'b1; bus.w_data = 32'hABCD_1234;
        tick();
        bus.led_low_cs = 1'b0; bus.w_data = 32'hFFFF_FFFF;
        checks++;
        if (led_w[0] !== 16'h1234 || m_disp !== 32'h0)
            $display("FAIL led_write: led=%h, want 1234", led_w[0]);
        else passed++;
        repeat (2) begin
            tick();
            checks++;
            if (led_w[0] !== 16'h1234)
                $display("FAIL led_hold: led=%h, want 1234", led_w[0]);
            else passed++;
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (led_w[k] !== m_led || an_w[k] !== exp_an(k) || seg_w[k] !== exp_seg(k))
                    $display("FAIL led_model dut%0d edge %0d: led=%h an=%h seg=%h, want led=%h an=%h seg=%h",
                             k, m_edges, led_w[k], an_w[k], seg_w[k], m_led, exp_an(k), exp_seg(k));
                else passed++;
            end
        end
        bus_idle();
    endtask

    task automatic test_display_scan();
        logic [7:0] want_seg [8];
        logic [7:0] want_an  [8];
        int seen;
        want_seg = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
        want_an  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        seen = 0;
        bus.led_high_cs = 1'b1; bus.w_data = 32'h89AB_CDEF;
        tick();
        bus_idle();
        for (int c = 0; c < 40; c++) begin
            tick();
            for (int d = 0; d < 8; d++) begin
                if (c >= 1 && an_w[0] === want_an[d]) begin
                    checks++; seen++;
                    if (seg_w[0] !== want_seg[d])
                        $display("FAIL scan_digit%0d: seg=%h, want %h", d, seg_w[0], want_seg[d]);
                    else passed++;
                end
            end
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (led_w[k] !== m_led || an_w[k] !== exp_an(k) || seg_w[k] !== exp_seg(k))
                    $display("FAIL scan_model dut%0d edge %0d: led=%h an=%h seg=%h, want led=%h an=%h seg=%h",
                             k, m_edges, led_w[k], an_w[k], seg_w[k], m_led, exp_an(k), exp_seg(k));
                else passed++;
            end
        end
        checks++;
        if (seen < 32)
            $display("FAIL scan_coverage: digit slots seen=%0d, want >= 32", seen);
        else passed++;
    endtask

    task automatic test_simultaneous();
        bus.led_low_cs = 1'b1; bus.led_high_cs = 1'b1; bus.w_data = 32'h0000_005A;
        tick();
        bus_idle();
        checks++;
        if (led_w[0] !== 16'h005A || m_disp !== 32'h0000_005A)
            $display("FAIL simultaneous_led: led=%h, want 005a", led_w[0]);
        else passed++;
        for (int c = 0; c < 34; c++) begin
            tick();
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (led_w[k] !== m_led || an_w[k] !== exp_an(k) || seg_w[k] !== exp_seg(k))
                    $display("FAIL simul_model dut%0d edge %0d: led=%h an=%h seg=%h, want led=%h an=%h seg=%h",
                             k, m_edges, led_w[k], an_w[k], seg_w[k], m_led, exp_an(k), exp_seg(k));
                else passed++;
            end
            if (an_w[0] === 8'hFE) begin
                checks++;
                if (seg_w[0] !== 8'h88) $display("FAIL simul_digit0: seg=%h, want 88", seg_w[0]); else passed++;
            end
            if (an_w[0] === 8'hFD) begin
                checks++;
                if (seg_w[0] !== 8'h92) $display("FAIL simul_digit1: seg=%h, want 92", seg_w[0]); else passed++;
            end
        end
    endtask

    task automatic test_blanking();
        int blank_slots;
        blank_slots = 0;
        bus.led_high_cs = 1'b1; bus.w_data = 32'h0000_0305;
        tick();
        bus_idle();
        for (int c = 0; c < 34; c++) begin
            tick();
            if (c >= 1) begin
                if (an_w[1] === 8'hFE) begin
                    checks++; if (seg_w[1] !== 8'h92) $display("FAIL blank_digit0: seg=%h, want 92", seg_w[1]); else passed++;
                end
                if (an_w[1] === 8'hFD) begin
                    checks++; if (seg_w[1] !== 8'hC0) $display("FAIL blank_digit1: seg=%h, want c0", seg_w[1]); else passed++;
                end
                if (an_w[1] === 8'hFB) begin
                    checks++; if (seg_w[1] !== 8'hB0) $display("FAIL blank_digit2: seg=%h, want b0", seg_w[1]); else passed++;
                end
                if (an_w[1] === 8'hFF) begin
                    blank_slots++;
                    checks++; if (seg_w[1] !== 8'hFF) $display("FAIL blank_seg: seg=%h, want ff", seg_w[1]); else passed++;
                end
            end
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (led_w[k] !== m_led || an_w[k] !== exp_an(k) || seg_w[k] !== exp_seg(k))
                    $display("FAIL blank_model dut%0d edge %0d: led=%h an=%h seg=%h, want led=%h an=%h seg=%h",
                             k, m_edges, led_w[k], an_w[k], seg_w[k], m_led, exp_an(k), exp_seg(k));
                else passed++;
            end
        end
        checks++;
        if (blank_slots < 20)
            $display("FAIL blank_slot_count: blanked cycles=%0d, want >= 20", blank_slots);
        else passed++;
    endtask

    task automatic test_write_mid_dwell();
        int budget;
        logic [31:0] newv;
        logic [7:0]  old_seg;
        budget = 0;
        // Advance the 1000-cycle instance to the middle of digit 2
        while (!(digit_of(2) == 2 && ((m_edges - 1) % 1000) == 300) && budget < 20000) begin
            tick();
            budget++;
        end
        checks++;
        if (budget >= 20000) $display("FAIL dwell_reach: budget expired at edge %0d", m_edges);
        else passed++;
        old_seg = hex7(m_disp[11:8]);
        newv = $urandom;
        newv[11:8] = m_disp[11:8] ^ 4'h5;
        bus.led_high_cs = 1'b1; bus.w_data = newv;
        tick();
        bus_idle();
        checks++;
        if (an_w[2] !== 8'hFB || seg_w[2] !== old_seg)
            $display("FAIL dwell_write_edge: an=%h seg=%h, want fb %h", an_w[2], seg_w[2], old_seg);
        else passed++;
        tick();
        checks++;
        if (an_w[2] !== 8'hFB || seg_w[2] !== hex7(newv[11:8]))
            $display("FAIL dwell_next_edge: an=%h seg=%h, want fb %h", an_w[2], seg_w[2], hex7(newv[11:8]));
        else passed++;
        for (int c = 0; c < 20; c++) begin
            tick();
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (led_w[k] !== m_led || an_w[k] !== exp_an(k) || seg_w[k] !== exp_seg(k))
                    $display("FAIL dwell_model dut%0d edge %0d: led=%h an=%h seg=%h, want led=%h an=%h seg=%h",
                             k, m_edges, led_w[k], an_w[k], seg_w[k], m_led, exp_an(k), exp_seg(k));
                else passed++;
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.led_low_cs  = ($urandom_range(0, 3) == 0);
            bus.led_high_cs = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       bus.w_data = 32'h0;
                1:       bus.w_data = 32'h1 << $urandom_range(0, 31);
                default: bus.w_data = $urandom;
            endcase
            tick();
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (led_w[k] !== m_led || an_w[k] !== exp_an(k) || seg_w[k] !== exp_seg(k))
                    $display("FAIL random_model dut%0d edge %0d: led=%h an=%h seg=%h, want led=%h an=%h seg=%h",
                             k, m_edges, led_w[k], an_w[k], seg_w[k], m_led, exp_an(k), exp_seg(k));
                else passed++;
            end
        end
        bus_idle();
    endtask

    initial begin
        bus_idle();
        m_led = 16'h0; m_disp = 32'h0; m_shown = 32'h0; m_edges = 0;
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        test_reset();
        test_led_write();
        test_display_scan();
        test_simultaneous();
        test_blanking();
        test_write_mid_dwell();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
